datamem_line_lat: RTL

- Line-granular backing data memory behind the data cache; services refill reads and writeback writes one cache line per request.
- Generalises the fixed 16-byte single-cycle store: parametrised line size, depth and access latency, per-byte write strobes, a busy/ready handshake with a real FSM, and consistent little-endian lane mapping.
- Sits between the cache controller and the memory map; synthesisable byte array, contents not reset.

---
 rtl/datamem_line_lat.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/datamem_line_lat.sv
// Line-granular backing data memory with configurable line size, depth and
// separate read/write latencies. Requests are accepted only in IDLE; each
// accepted request produces exactly one mem_ready pulse. Array contents are
// not reset. Byte i of a line sits in bits [8i+7:8i].
// Optional: define DATAMEM_ALIGN_CHECK_EN to add mem_err, which flags (and
// suppresses) requests whose address is not line-aligned.
module datamem_line_lat #(
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned RD_LATENCY = 4,
   parameter int unsigned WR_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_req,
   input  logic                      mem_we,
   input  logic [31:0]               mem_addr,
   input  logic [8*LINE_BYTES-1:0]   mem_wdata,
   input  logic [LINE_BYTES-1:0]     mem_wstrb,
   output logic [8*LINE_BYTES-1:0]   mem_rdata,
   output logic                      mem_ready,
   output logic                      mem_busy
`ifdef DATAMEM_ALIGN_CHECK_EN
   ,
   output logic                      mem_err
`endif
);

   localparam int unsigned OFF_W   = $clog2(LINE_BYTES);
   localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                        state;
   logic [CNT_W-1:0]              cnt;
   logic [CNT_W-1:0]              lat_load;
   logic [ADDR_WIDTH-OFF_W-1:0]   line_q;
   logic                          we_q;
   logic [8*LINE_BYTES-1:0]       wdata_q;
   logic [LINE_BYTES-1:0]         wstrb_q;
   logic                          do_access;
   logic [7:0]                    mem [DEPTH];

   // Address bits above the implemented depth wrap; offset bits within a line
   // are dropped when forming the line address.
   logic                          unused_addr_bits;
   assign unused_addr_bits = &{1'b0, mem_addr[31:ADDR_WIDTH], mem_addr[OFF_W-1:0]};

`ifdef DATAMEM_ALIGN_CHECK_EN
   logic                          misal_q;
   assign do_access = (state == ST_RESP) && !misal_q;
`else
   assign do_access = (state == ST_RESP);
`endif

   // Counter preload: one less than the latency of the requested access kind
   always_comb begin
      lat_load = mem_we ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
   end

   // Control FSM: accept, count down latency, then complete with a ready pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mem_ready <= 1'b0;
         mem_busy  <= 1'b0;
         line_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
`ifdef DATAMEM_ALIGN_CHECK_EN
         misal_q   <= 1'b0;
         mem_err   <= 1'b0;
`endif
      end else begin
         mem_ready <= 1'b0;
`ifdef DATAMEM_ALIGN_CHECK_EN
         mem_err   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // A request seen during the ready cycle is deliberately ignored
               if (mem_req && !mem_ready) begin
                  line_q   <= mem_addr[ADDR_WIDTH-1:OFF_W];
                  we_q     <= mem_we;
                  wdata_q  <= mem_wdata;
                  wstrb_q  <= mem_wstrb;
                  cnt      <= lat_load;
                  mem_busy <= 1'b1;
`ifdef DATAMEM_ALIGN_CHECK_EN
                  misal_q  <= |mem_addr[OFF_W-1:0];
`endif
                  state    <= (lat_load == '0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               mem_ready <= 1'b1;
               mem_busy  <= 1'b0;
`ifdef DATAMEM_ALIGN_CHECK_EN
               mem_err   <= misal_q;
`endif
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read port: load the captured line on the completion edge, hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rdata <= '0;
      end else if (do_access && !we_q) begin
         for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            mem_rdata[8*i +: 8] <= mem[{line_q, OFF_W'(i)}];
         end
      end
   end

   // Write port: commit strobed bytes on the completion edge; array is not reset
   always_ff @(posedge clk) begin
      if (do_access && we_q) begin
         for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (wstrb_q[i]) begin
               mem[{line_q, OFF_W'(i)}] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
